// File: rtl/control_step_sequencer.sv
// One-hot T-step generator for the multi-cycle control unit.
// Optional stall-cycle counter built only when SEQ_STALL_COUNT_EN is defined.
module control_step_sequencer #(
   parameter  int MAX_STEPS = 8,
   localparam int STEP_W    = (MAX_STEPS > 2) ? $clog2(MAX_STEPS) : 1
) (
   input  logic                 iClk,
   input  logic                 nRst,
   input  logic                 iRun,
   input  logic                 iHalt,
   input  logic                 iStall,
   input  logic                 iEnd,
   input  logic [STEP_W-1:0]    iLastStep,
   output logic [MAX_STEPS-1:0] oStep,
   output logic [STEP_W-1:0]    oStepIdx,
   output logic                 oFetch,
   output logic                 oInstrDone,
   output logic                 oHalted,
   output logic                 oBusy,
   output logic                 oFault,
   output logic [15:0]          oStallCount
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      HALTED = 2'd2
   } state_t;

   localparam logic [STEP_W-1:0] LAST = STEP_W'(MAX_STEPS - 1);

   state_t            state;
   state_t            state_nxt;
   logic [STEP_W-1:0] step;
   logic [STEP_W-1:0] step_nxt;
   logic              pend;
   logic              pend_nxt;
   logic              done;
   logic              done_nxt;
   logic              fault;
   logic              fault_nxt;
   logic              complete;
   logic              overrun;

   always_ff @(posedge iClk) begin
      if (!nRst) begin
         state <= IDLE;
         step  <= '0;
         pend  <= 1'b0;
         done  <= 1'b0;
         fault <= 1'b0;
      end else begin
         state <= state_nxt;
         step  <= step_nxt;
         pend  <= pend_nxt;
         done  <= done_nxt;
         fault <= fault_nxt;
      end
   end

   // T0 ignores iLastStep: decode has not produced it yet.
   always_comb begin
      complete = iEnd
               || ((step != '0) && (step >= iLastStep))
               || (step == LAST);
      overrun  = (step == LAST) && !iEnd && (iLastStep > LAST);
   end

   always_comb begin
      state_nxt = state;
      step_nxt  = step;
      pend_nxt  = pend;
      done_nxt  = 1'b0;
      fault_nxt = fault;
      unique case (state)
         IDLE: begin
            if (iRun) begin
               state_nxt = RUN;
               step_nxt  = '0;
            end
         end
         RUN: begin
            if (iHalt)
               pend_nxt = 1'b1;
            if (!iStall) begin
               if (complete) begin
                  done_nxt = 1'b1;
                  step_nxt = '0;
                  if (overrun)
                     fault_nxt = 1'b1;
                  if (pend || iHalt) begin
                     state_nxt = HALTED;
                     pend_nxt  = 1'b0;
                  end
               end else begin
                  step_nxt = step + 1'b1;
               end
            end
         end
         HALTED: begin
            step_nxt = '0;
            if (iRun) begin
               state_nxt = RUN;
               pend_nxt  = 1'b0;
            end
         end
         default: begin
            state_nxt = IDLE;
            step_nxt  = '0;
         end
      endcase
   end

   always_comb begin
      oStep      = '0;
      oStepIdx   = step;
      oFetch     = 1'b0;
      oBusy      = 1'b0;
      oHalted    = 1'b0;
      oInstrDone = done;
      oFault     = fault;
      if (state == RUN) begin
         oStep  = MAX_STEPS'(1) << step;
         oFetch = (step == '0);
         oBusy  = 1'b1;
      end
      if (state == HALTED)
         oHalted = 1'b1;
   end

`ifdef SEQ_STALL_COUNT_EN
   logic [15:0] stall_cnt;

   always_ff @(posedge iClk) begin
      if (!nRst)
         stall_cnt <= '0;
      else if ((state == RUN) && iStall && (stall_cnt != 16'hFFFF))
         stall_cnt <= stall_cnt + 16'd1;
   end

   assign oStallCount = stall_cnt;
`else
   assign oStallCount = 16'd0;
`endif

endmodule

// File: tb/tb_control_step_sequencer.sv
// Directed bench for control_step_sequencer (MAX_STEPS=8 and MAX_STEPS=6).
// Expected values are hand-derived per step.
module tb_control_step_sequencer;

   logic        clk = 1'b0;
   logic        nRst;
   logic        iRun;
   logic        iHalt;
   logic        iStall;
   logic        iEnd;
   logic [2:0]  iLastStep;

   logic [7:0]  step8;
   logic [2:0]  idx8;
   logic        fetch8;
   logic        done8;
   logic        halted8;
   logic        busy8;
   logic        fault8;
   logic [15:0] scnt8;

   logic [5:0]  step6;
   logic [2:0]  idx6;
   logic        fetch6;
   logic        done6;
   logic        halted6;
   logic        busy6;
   logic        fault6;
   logic [15:0] scnt6;

   int total = 0;
   int bad   = 0;

   control_step_sequencer #(.MAX_STEPS(8)) dut8 (
      .iClk(clk), .nRst(nRst), .iRun(iRun), .iHalt(iHalt),
      .iStall(iStall), .iEnd(iEnd), .iLastStep(iLastStep),
      .oStep(step8), .oStepIdx(idx8), .oFetch(fetch8),
      .oInstrDone(done8), .oHalted(halted8), .oBusy(busy8),
      .oFault(fault8), .oStallCount(scnt8)
   );

   control_step_sequencer #(.MAX_STEPS(6)) dut6 (
      .iClk(clk), .nRst(nRst), .iRun(iRun), .iHalt(iHalt),
      .iStall(iStall), .iEnd(iEnd), .iLastStep(iLastStep),
      .oStep(step6), .oStepIdx(idx6), .oFetch(fetch6),
      .oInstrDone(done6), .oHalted(halted6), .oBusy(busy6),
      .oFault(fault6), .oStallCount(scnt6)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      nRst = 1'b0;
      iRun = 1'b0; iHalt = 1'b0; iStall = 1'b0; iEnd = 1'b0;
      tick();
      tick();
      nRst = 1'b1;
   endtask

   task automatic start(input logic [2:0] last);
      iLastStep = last;
      iRun = 1'b1;
      tick();
      iRun = 1'b0;
   endtask

   initial begin
      logic [15:0] exp_scnt;
      iLastStep = 3'd0;
      do_reset();

      // reset state
      chk("rst_step", step8, 8'h00);
      chk("rst_idx", idx8, 3'd0);
      chk("rst_busy", busy8, 1'b0);
      chk("rst_fetch", fetch8, 1'b0);
      chk("rst_halt", halted8, 1'b0);
      chk("rst_done", done8, 1'b0);
      chk("rst_fault", fault8, 1'b0);
      chk("rst_scnt", scnt8, 16'd0);

      // 1: last=4
      start(3'd4);
      chk("t1_T0", step8, 8'h01);
      chk("t1_fetch0", fetch8, 1'b1);
      chk("t1_done0", done8, 1'b0);
      tick(); chk("t1_T1", step8, 8'h02);
      tick(); chk("t1_T2", step8, 8'h04);
      tick(); chk("t1_T3", step8, 8'h08);
      tick(); chk("t1_T4", step8, 8'h10);
      chk("t1_idx4", idx8, 3'd4);
      chk("t1_done4", done8, 1'b0);
      tick(); chk("t1_wrap", step8, 8'h01);
      chk("t1_done", done8, 1'b1);
      chk("t1_fetch", fetch8, 1'b1);
      tick(); chk("t1_T1b", step8, 8'h02);
      chk("t1_done_off", done8, 1'b0);

      // 2: stall at T2
      do_reset();
      start(3'd5);
      tick(); tick();
      chk("t2_T2", step8, 8'h04);
      iStall = 1'b1;
      tick(); chk("t2_s1", step8, 8'h04);
      tick(); chk("t2_s2", step8, 8'h04);
      tick(); chk("t2_s3", step8, 8'h04);
      iStall = 1'b0;
      tick(); chk("t2_T3", step8, 8'h08);
`ifdef SEQ_STALL_COUNT_EN
      exp_scnt = 16'd3;
`else
      exp_scnt = 16'd0;
`endif
      chk("t2_scnt", scnt8, exp_scnt);

      // 3: early end at T2
      do_reset();
      start(3'd5);
      tick(); tick();
      chk("t3_T2", step8, 8'h04);
      iEnd = 1'b1;
      tick(); iEnd = 1'b0;
      chk("t3_T0", step8, 8'h01);
      chk("t3_done", done8, 1'b1);
      tick(); chk("t3_T1", step8, 8'h02);

      // 4: halt at instruction boundary
      do_reset();
      start(3'd3);
      tick(); chk("t4_T1", step8, 8'h02);
      iHalt = 1'b1;
      tick(); iHalt = 1'b0;
      chk("t4_T2", step8, 8'h04);
      tick(); chk("t4_T3", step8, 8'h08);
      tick();
      chk("t4_step", step8, 8'h00);
      chk("t4_halted", halted8, 1'b1);
      chk("t4_busy", busy8, 1'b0);
      chk("t4_done", done8, 1'b1);
      tick();
      chk("t4_hold", halted8, 1'b1);
      chk("t4_done_off", done8, 1'b0);
      iRun = 1'b1;
      tick(); iRun = 1'b0;
      chk("t4_resume", step8, 8'h01);
      chk("t4_unhalt", halted8, 1'b0);

      // 5: overrun on MAX_STEPS=6 instance
      do_reset();
      start(3'd7);
      chk("t5_T0", step6, 6'h01);
      tick(); tick(); tick(); tick(); tick();
      chk("t5_T5", step6, 6'h20);
      chk("t5_idx5", idx6, 3'd5);
      chk("t5_nofault", fault6, 1'b0);
      tick();
      chk("t5_wrap", step6, 6'h01);
      chk("t5_done", done6, 1'b1);
      chk("t5_fault", fault6, 1'b1);
      chk("t8_nofault", fault8, 1'b0);
      tick(); tick(); tick();
      chk("t5_sticky", fault6, 1'b1);

      // 6: reset mid-instruction
      do_reset();
      start(3'd5);
      tick(); tick(); tick();
      chk("t6_T3", step8, 8'h08);
      nRst = 1'b0;
      tick();
      chk("t6_step", step8, 8'h00);
      chk("t6_busy", busy8, 1'b0);
      chk("t6_done", done8, 1'b0);
      chk("t6_fault6", fault6, 1'b0);
      nRst = 1'b1;
      tick();
      chk("t6_idle", busy8, 1'b0);
      chk("t6_idle_done", done8, 1'b0);
      start(3'd5);
      chk("t6_T0", step8, 8'h01);
      chk("t6_nodone", done8, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
